acq_sequencer: RTL
==================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter: N_SENS, default 10, number of sensor channels; bit map equals timing-manager en_bits[9:0] (AMDS0-3, eddy0-3, encoder, ADC).
REQ-002 Parameter: TW, default 16, width of timer, timeout_limit, cycle_time and overrun_count.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 trigger  in  1  one-cycle acquisition request from the timing manager.
REQ-006 en_bits  in  N_SENS  sensor enable mask, sampled only on trigger acceptance.
REQ-007 done  in  N_SENS  per-sensor done level; only rising edges are significant.
REQ-008 timeout_limit  in  TW  WAIT timeout in clk cycles; 0 disables timeout.
REQ-009 clr_status  in  1  one-cycle clear of timeout_flags and overrun_count.
REQ-010 start  out  N_SENS  one-cycle start pulse per sensor.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 cycle_done  out  1  one-cycle pulse at acquisition completion.
REQ-013 timeout_flags  out  N_SENS  sticky per-sensor timeout flags.
REQ-014 cycle_time  out  TW  timer value latched at completion.
REQ-015 overrun_count  out  TW  count of triggers rejected while busy, saturating.

Function
REQ-016 FSM states IDLE, LAUNCH, WAIT, COMPLETE; registered outputs; no combinational input-to-output paths.
REQ-017 IDLE: trigger with en_bits != 0 -> snapshot en_bits into en_snap, clear pending and timer, go to LAUNCH; trigger with en_bits == 0 is ignored (no state change, no overrun).
REQ-018 LAUNCH lasts exactly N_SENS cycles, index k = 0..N_SENS-1 ascending; in cycle k, start[k] = en_snap[k]; disabled channels consume their slot with no pulse.
REQ-019 pending[k] set in the cycle after start[k]; a done[k] rising edge in the same cycle as start[k], or while pending[k] = 0, is ignored.
REQ-020 Rising edge of done[k] (done[k]=1, previous-cycle sample 0) while pending[k]=1 clears pending[k]; valid in LAUNCH and WAIT.
REQ-021 After the last LAUNCH slot -> WAIT.
REQ-022 Timer: increments every cycle in LAUNCH and WAIT starting at 0 on LAUNCH entry; saturates at all-ones.
REQ-023 WAIT -> COMPLETE when pending == 0.
REQ-024 WAIT -> COMPLETE when timeout_limit != 0 and timer >= timeout_limit with pending != 0; timeout_flags |= pending, pending cleared, same cycle.
REQ-025 Pending-clear and timeout in the same cycle: the done edge wins for that channel (no flag).
REQ-026 COMPLETE: exactly one cycle; cycle_done = 1, cycle_time <= timer; then IDLE.
REQ-027 Trigger in LAUNCH, WAIT or COMPLETE is rejected: overrun_count +1, saturating at all-ones; sequence unaffected.
REQ-028 clr_status clears timeout_flags and overrun_count; simultaneous set events are applied after the clear (flags set, count = 1).
REQ-029 start pulses are never issued outside LAUNCH.

Reset
REQ-030 rst_n low: state IDLE; start, busy, cycle_done, pending, en_snap, timer, timeout_flags, cycle_time, overrun_count = 0; done edge-detect registers = 0.
REQ-031 Reset mid-sequence aborts immediately; no cycle_done, no further start pulses; resumes in IDLE.

Verification
REQ-032 en_bits=0x201, trigger, done[0] at cycle 3, done[9] at cycle 20 after trigger -> start[0] at LAUNCH slot 0, start[9] at slot 9, cycle_done once, timeout_flags=0.
REQ-033 en_bits=0x010, timeout_limit=50, done never rises -> COMPLETE with timer=50, timeout_flags=0x010, cycle_time=50.
REQ-034 Three triggers during busy, then clr_status with a fourth -> overrun_count reaches 3, then reads 1.
REQ-035 en_bits=0, trigger -> busy stays 0, no start, overrun_count unchanged.
REQ-036 done[4] held high from the previous cycle, en_bits=0x010, no new edge, timeout_limit=0 -> stays in WAIT; rst_n pulse -> IDLE, all outputs 0.
REQ-037 done edge coincident with start[k] -> ignored; pending persists until the next edge or timeout.

Source files
------------

// File: rtl/acq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : acq_sequencer
//  Description : Acquisition sequencer. On an accepted trigger, snapshots the
//                sensor enable mask, issues one start pulse per enabled sensor
//                in ascending slot order, then waits for every started sensor
//                to report done (rising edge) or for a timeout. It reports
//                completion, elapsed time, sticky timeout flags and a
//                saturating count of triggers rejected while busy.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   1       clock, rising edge
//    rst_n          in   1       asynchronous active-low reset
//    trigger        in   1       one-cycle acquisition request
//    en_bits        in   N_SENS  sensor enable mask (sampled on acceptance)
//    done           in   N_SENS  per-sensor done level (rising edge counts)
//    timeout_limit  in   TW      wait timeout in cycles, 0 = no timeout
//    clr_status     in   1       clears timeout_flags and overrun_count
//    start          out  N_SENS  one-cycle start pulse per sensor
//    busy           out  1       sequencer not idle
//    cycle_done     out  1       one-cycle completion pulse
//    timeout_flags  out  N_SENS  sticky per-sensor timeout flags
//    cycle_time     out  TW      timer value latched at completion
//    overrun_count  out  TW      saturating count of rejected triggers
// ============================================================================
module acq_sequencer #(
    parameter int N_SENS = 10,
    parameter int TW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trigger,
    input  logic [N_SENS-1:0] en_bits,
    input  logic [N_SENS-1:0] done,
    input  logic [TW-1:0]     timeout_limit,
    input  logic              clr_status,
    output logic [N_SENS-1:0] start,
    output logic              busy,
    output logic              cycle_done,
    output logic [N_SENS-1:0] timeout_flags,
    output logic [TW-1:0]     cycle_time,
    output logic [TW-1:0]     overrun_count
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_LAUNCH   = 2'd1;
    localparam logic [1:0] c_WAIT     = 2'd2;
    localparam logic [1:0] c_COMPLETE = 2'd3;

    localparam int                c_IW        = (N_SENS > 1) ? $clog2(N_SENS) : 1;
    localparam logic [c_IW-1:0]   c_LAST_SLOT = c_IW'(N_SENS - 1);
    localparam logic [c_IW-1:0]   c_SLOT_ONE  = c_IW'(1);
    localparam logic [N_SENS-1:0] c_CH_ONE    = N_SENS'(1);
    localparam logic [TW-1:0]     c_TW_ONE    = TW'(1);
    localparam logic [TW-1:0]     c_TW_MAX    = {TW{1'b1}};

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [c_IW-1:0]   r_slot;
    logic [c_IW-1:0]   w_slot_next;
    logic [N_SENS-1:0] r_en_snap;
    logic [N_SENS-1:0] r_pending;
    logic [N_SENS-1:0] r_done_q;
    logic [TW-1:0]     r_timer;
    logic [N_SENS-1:0] r_start;
    logic [N_SENS-1:0] w_next_start;
    logic              r_busy;
    logic              r_cycle_done;
    logic [N_SENS-1:0] r_timeout_flags;
    logic [TW-1:0]     r_cycle_time;
    logic [TW-1:0]     r_overrun_count;

    logic              w_accept;
    logic              w_overrun;
    logic              w_timeout;
    logic              w_to_complete;
    logic [N_SENS-1:0] w_done_rise;
    logic [N_SENS-1:0] w_pending_kept;
    logic [TW-1:0]     w_timer_inc;
    logic [TW-1:0]     w_ov_base;
    logic [TW-1:0]     w_ov_next;
    logic [N_SENS-1:0] w_flags_next;

    assign w_accept       = (r_state == c_IDLE) && trigger && (en_bits != '0);
    assign w_overrun      = trigger && (r_state != c_IDLE);
    assign w_done_rise    = done & ~r_done_q;
    // A done edge on a pending channel wins over a coincident timeout.
    assign w_pending_kept = r_pending & ~w_done_rise;
    assign w_timeout      = (r_state == c_WAIT) && (timeout_limit != '0) &&
                            (r_timer >= timeout_limit) && (r_pending != '0);
    assign w_to_complete  = (w_next_state == c_COMPLETE);
    assign w_timer_inc    = (r_timer == c_TW_MAX) ? r_timer : r_timer + c_TW_ONE;
    assign w_slot_next    = r_slot + c_SLOT_ONE;

    // Clear first, then apply any set event from the same cycle.
    assign w_ov_base      = clr_status ? '0 : r_overrun_count;
    assign w_ov_next      = (w_overrun && (w_ov_base != c_TW_MAX)) ?
                            w_ov_base + c_TW_ONE : w_ov_base;
    assign w_flags_next   = (clr_status ? '0 : r_timeout_flags) |
                            (w_timeout ? w_pending_kept : '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next start vector. start is registered, so the pulse
    // for slot k is prepared on the edge that enters slot k.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_start = '0;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = c_LAUNCH;
                    w_next_start = en_bits & c_CH_ONE;
                end
            end
            c_LAUNCH: begin
                if (r_slot == c_LAST_SLOT) begin
                    w_next_state = c_WAIT;
                end else begin
                    w_next_start = r_en_snap & (c_CH_ONE << w_slot_next);
                end
            end
            c_WAIT: begin
                if ((r_pending == '0) || w_timeout) begin
                    w_next_state = c_COMPLETE;
                end
            end
            c_COMPLETE: begin
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot          <= '0;
            r_en_snap       <= '0;
            r_pending       <= '0;
            r_done_q        <= '0;
            r_timer         <= '0;
            r_start         <= '0;
            r_busy          <= 1'b0;
            r_cycle_done    <= 1'b0;
            r_timeout_flags <= '0;
            r_cycle_time    <= '0;
            r_overrun_count <= '0;
        end else begin
            r_done_q        <= done;
            r_start         <= w_next_start;
            r_busy          <= (w_next_state != c_IDLE);
            r_cycle_done    <= w_to_complete;
            r_timeout_flags <= w_flags_next;
            r_overrun_count <= w_ov_next;

            if (w_to_complete) begin
                r_cycle_time <= r_timer;
            end

            if (w_accept) begin
                r_en_snap <= en_bits;
                r_pending <= '0;
                r_timer   <= '0;
                r_slot    <= '0;
            end else begin
                case (r_state)
                    c_LAUNCH: begin
                        // A channel becomes pending the cycle after its
                        // start pulse, so an edge coincident with start is
                        // not counted.
                        r_pending <= w_pending_kept | r_start;
                        r_timer   <= w_timer_inc;
                        if (r_slot != c_LAST_SLOT) begin
                            r_slot <= w_slot_next;
                        end
                    end
                    c_WAIT: begin
                        r_pending <= w_timeout ? '0 : w_pending_kept;
                        // Timer holds on the exit edge so cycle_time and
                        // timer agree during COMPLETE.
                        if (!w_to_complete) begin
                            r_timer <= w_timer_inc;
                        end
                    end
                    default: begin
                        r_pending <= r_pending;
                    end
                endcase
            end
        end
    end

    assign start         = r_start;
    assign busy          = r_busy;
    assign cycle_done    = r_cycle_done;
    assign timeout_flags = r_timeout_flags;
    assign cycle_time    = r_cycle_time;
    assign overrun_count = r_overrun_count;

endmodule
`default_nettype wire
